// File: rtl/serialiser_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// serialiser_ctrl_pkg
//   Shared constants and state encoding for the 5x5-window-to-column serialiser.
//   Used by the serialiser controller, serialiser datapath instantiations and
//   the cumulative-sum controller.
//   Contents:
//     COLS      columns per window (select runs 0..COLS-1)
//     SEL_W     width of the datapath column select
//     IDLE_SEL  select code meaning "no column" (datapath outputs 0)
//     state_t   controller state encoding (IDLE / ARMED / RUN)
// -----------------------------------------------------------------------------
package serialiser_ctrl_pkg;

    localparam int COLS  = 5;
    localparam int SEL_W = 3;

    localparam logic [SEL_W-1:0] IDLE_SEL = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

endpackage

// File: rtl/serialiser_ctrl.sv
// -----------------------------------------------------------------------------
// serialiser_ctrl
//   Sequences the serialiser datapath: accepts one 5x5 window per handshake and
//   steps the column select 0..COLS-1 on consecutive cycles. Flags each valid
//   column, the last column of each window and the end of a frame.
//   Parameters:
//     FRAME_WINDOWS  windows per frame (>= 1)
//     WCNT_W         window counter width (2**WCNT_W > FRAME_WINDOWS)
//   Ports:
//     clk, rst       clock (rising edge), asynchronous active-high reset
//     i_start        pulse: arm a new frame, aborting any frame in progress
//     i_valid        upstream window present this cycle
//     o_ready        controller accepts a window this cycle
//     o_select       datapath column select (IDLE_SEL when no column)
//     o_col_valid    o_select addresses a real column
//     o_win_last     current column is the last column of its window
//     o_frame_done   1-cycle pulse after the last column of the frame
//     o_busy         a frame is armed (ARMED or RUN)
//     i_clr_err      clears o_overrun
//     o_overrun      sticky: window offered while not ready during a frame
// -----------------------------------------------------------------------------
module serialiser_ctrl
    import serialiser_ctrl_pkg::*;
#(
    parameter int FRAME_WINDOWS = 16,
    parameter int WCNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [SEL_W-1:0] o_select,
    output logic             o_col_valid,
    output logic             o_win_last,
    output logic             o_frame_done,
    output logic             o_busy,
    input  logic             i_clr_err,
    output logic             o_overrun
);

    localparam logic [SEL_W-1:0]  LAST_COL = SEL_W'(COLS - 1);
    localparam logic [WCNT_W-1:0] LAST_WIN = WCNT_W'(FRAME_WINDOWS - 1);
    localparam logic [WCNT_W-1:0] MAX_WIN  = WCNT_W'(FRAME_WINDOWS);

    state_t            state;
    logic [SEL_W-1:0]  col;
    logic [WCNT_W-1:0] wcnt;
    logic              frame_done_q;
    logic              overrun_q;

    logic ready;
    logic accept;
    logic armed_or_run;

    // A window is only taken from ARMED. The controller drops back to ARMED
    // in the cycle after the last column, so the next window lands there with
    // zero bubble while column COLS-1 keeps its own cycle.
    assign ready        = (state == ST_ARMED) && !i_start;
    assign accept       = i_valid && ready;
    assign armed_or_run = (state != ST_IDLE);

    // Column 0 is issued in the accept cycle itself so the datapath can use
    // the live window inputs; the remaining columns come from the col register.
    // i_start drops the in-flight window immediately.
    always_comb begin
        o_select    = IDLE_SEL;
        o_col_valid = 1'b0;
        o_win_last  = 1'b0;
        if (!i_start) begin
            if (accept) begin
                o_select    = '0;
                o_col_valid = 1'b1;
                o_win_last  = (LAST_COL == '0);
            end else if (state == ST_RUN) begin
                o_select    = col;
                o_col_valid = 1'b1;
                o_win_last  = (col == LAST_COL);
            end
        end
    end

    // State register, column/window counters and the registered flags.
    // wcnt counts completed windows in the frame; when the last column of
    // window FRAME_WINDOWS issues the frame ends and wcnt is cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            col          <= '0;
            wcnt         <= '0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;

            // Set takes priority over clear.
            if (i_valid && !ready && armed_or_run) begin
                overrun_q <= 1'b1;
            end else if (i_clr_err) begin
                overrun_q <= 1'b0;
            end

            if (i_start) begin
                state <= ST_ARMED;
                col   <= '0;
                wcnt  <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        col  <= '0;
                        wcnt <= '0;
                    end
                    ST_ARMED: begin
                        if (accept) begin
                            state <= ST_RUN;
                            col   <= SEL_W'(1);
                        end
                    end
                    ST_RUN: begin
                        if (col == LAST_COL) begin
                            col <= '0;
                            if (wcnt == LAST_WIN) begin
                                state        <= ST_IDLE;
                                wcnt         <= '0;
                                frame_done_q <= 1'b1;
                            end else begin
                                state <= ST_ARMED;
                                if (wcnt != MAX_WIN) begin
                                    wcnt <= wcnt + WCNT_W'(1);
                                end
                            end
                        end else begin
                            col <= col + SEL_W'(1);
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        col   <= '0;
                        wcnt  <= '0;
                    end
                endcase
            end
        end
    end

    assign o_ready      = ready;
    assign o_busy       = armed_or_run;
    assign o_frame_done = frame_done_q;
    assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_serialiser_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serialiser_ctrl
//   Self-checking bench for serialiser_ctrl (FRAME_WINDOWS = 3). A queue-based
//   reference model tracks the frame: an accepted window pushes its column list
//   into a queue and each cycle issues the head of that queue. Directed steps
//   cover the listed scenarios, followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_serialiser_ctrl;
    import serialiser_ctrl_pkg::*;

    localparam int FW = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             i_start;
    logic             i_valid;
    logic             i_clr_err;
    logic             o_ready;
    logic [SEL_W-1:0] o_select;
    logic             o_col_valid;
    logic             o_win_last;
    logic             o_frame_done;
    logic             o_busy;
    logic             o_overrun;

    always #5 clk = ~clk;

    serialiser_ctrl #(
        .FRAME_WINDOWS(FW),
        .WCNT_W       (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .o_select    (o_select),
        .o_col_valid (o_col_valid),
        .o_win_last  (o_win_last),
        .o_frame_done(o_frame_done),
        .o_busy      (o_busy),
        .i_clr_err   (i_clr_err),
        .o_overrun   (o_overrun)
    );

    int compared   = 0;
    int mismatched = 0;

    // Reference model: pending columns of the window in flight, frame armed,
    // windows finished in this frame, sticky overrun and pending done pulse.
    int colq[$];
    bit m_busy;
    int m_windows;
    bit m_ovr;
    bit m_done;

    // Values sampled in the most recent step, used by the directed checks.
    bit          last_accept;
    logic [31:0] obs_sel;
    logic        obs_last;
    logic        obs_ovr;
    logic        obs_done;
    int          cyc = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        colq.delete();
        m_busy    = 1'b0;
        m_windows = 0;
        m_ovr     = 1'b0;
        m_done    = 1'b0;
    endtask

    // One clock cycle: drive inputs after the falling edge, compare against the
    // model, then advance the model across the rising edge.
    task automatic applyStimulus(input bit start, input bit valid, input bit clr);
        bit exp_ready;
        bit have;
        int cur;
        bit done_next;
        i_start   = start;
        i_valid   = valid;
        i_clr_err = clr;
        #1;
        exp_ready   = m_busy && (colq.size() == 0) && !start;
        last_accept = valid && exp_ready;
        have = 1'b0;
        cur  = 0;
        if (!start) begin
            if (last_accept) begin
                for (int k = 0; k < COLS; k++) colq.push_back(k);
            end
            if (colq.size() > 0) begin
                cur  = colq.pop_front();
                have = 1'b1;
            end
        end
        obs_sel  = 32'(o_select);
        obs_last = o_win_last;
        obs_ovr  = o_overrun;
        obs_done = o_frame_done;
        checkOutput("ready",      32'(o_ready),      32'(exp_ready));
        checkOutput("select",     32'(o_select),     have ? 32'(cur) : 32'(IDLE_SEL));
        checkOutput("col_valid",  32'(o_col_valid),  32'(have));
        checkOutput("win_last",   32'(o_win_last),   32'(have && (cur == COLS - 1)));
        checkOutput("busy",       32'(o_busy),       32'(m_busy));
        checkOutput("overrun",    32'(o_overrun),    32'(m_ovr));
        checkOutput("frame_done", 32'(o_frame_done), 32'(m_done));
        @(posedge clk);
        done_next = 1'b0;
        if (valid && !exp_ready && m_busy) m_ovr = 1'b1;
        else if (clr)                      m_ovr = 1'b0;
        if (start) begin
            m_busy    = 1'b1;
            m_windows = 0;
            colq.delete();
        end else if (have && (cur == COLS - 1)) begin
            m_windows++;
            if (m_windows == FW) begin
                m_busy    = 1'b0;
                m_windows = 0;
                done_next = 1'b1;
            end
        end
        m_done = done_next;
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        int t0;
        int accepts[$];
        int dones[$];
        bit rs;
        bit rv;
        bit rc;

        i_start   = 1'b0;
        i_valid   = 1'b0;
        i_clr_err = 1'b0;
        rst       = 1'b1;
        modelReset();
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_select",    32'(o_select),     32'(IDLE_SEL));
        checkOutput("rst_col_valid", 32'(o_col_valid),  32'd0);
        checkOutput("rst_ready",     32'(o_ready),      32'd0);
        checkOutput("rst_busy",      32'(o_busy),       32'd0);
        checkOutput("rst_overrun",   32'(o_overrun),    32'd0);
        checkOutput("rst_done",      32'(o_frame_done), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 1: valid with no frame armed is ignored silently
        $display("[TB] idle valid");
        repeat (10) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            checkOutput("t1_sel", obs_sel, 32'(IDLE_SEL));
            checkOutput("t1_ovr", 32'(obs_ovr), 32'd0);
        end

        // 2: single window
        $display("[TB] single window");
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("t2_accept", 32'(last_accept), 32'd1);
        for (int k = 0; k < COLS; k++) begin
            if (k > 0) applyStimulus(1'b0, 1'b0, 1'b0);
            checkOutput("t2_sel", obs_sel, 32'(k));
            checkOutput("t2_last", 32'(obs_last), 32'(k == COLS - 1));
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("t2_sel_after", obs_sel, 32'(IDLE_SEL));

        // 3: full frame with valid held high
        $display("[TB] full frame");
        applyStimulus(1'b1, 1'b0, 1'b0);
        t0 = -1;
        for (int i = 0; i < 24; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            if (last_accept) begin
                if (t0 < 0) t0 = i;
                accepts.push_back(i - t0);
            end
            if (obs_done) dones.push_back(i - t0);
        end
        checkOutput("t3_n_accepts", 32'(accepts.size()), 32'd3);
        if (accepts.size() == 3) begin
            checkOutput("t3_acc1", 32'(accepts[1]), 32'd5);
            checkOutput("t3_acc2", 32'(accepts[2]), 32'd10);
        end
        checkOutput("t3_n_dones", 32'(dones.size()), 32'd1);
        if (dones.size() == 1) checkOutput("t3_done_at", 32'(dones[0]), 32'd15);
        checkOutput("t3_busy_end", 32'(o_busy), 32'd0);

        // 4: overrun during a window, then clear
        $display("[TB] overrun");
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("t4_sel_t2", obs_sel, 32'd2);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("t4_ovr_t3", 32'(obs_ovr), 32'd1);
        checkOutput("t4_sel_t3", obs_sel, 32'd3);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("t4_ovr_t7", 32'(obs_ovr), 32'd0);

        // 5: re-arm mid-window
        $display("[TB] restart mid-window");
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("t5_sel_t4", obs_sel, 32'(IDLE_SEL));
        checkOutput("t5_no_done", 32'(obs_done), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("t5_restart_sel", obs_sel, 32'd0);
        repeat (COLS) applyStimulus(1'b0, 1'b0, 1'b0);

        // 6: asynchronous reset mid-window
        $display("[TB] async reset");
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        i_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checkOutput("t6_sel",       32'(o_select),    32'(IDLE_SEL));
        checkOutput("t6_col_valid", 32'(o_col_valid), 32'd0);
        checkOutput("t6_busy",      32'(o_busy),      32'd0);
        modelReset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("t6_first_sel", obs_sel, 32'd0);
        repeat (COLS) applyStimulus(1'b0, 1'b0, 1'b0);

        // Randomized traffic
        $display("[TB] random run");
        for (int i = 0; i < 600; i++) begin
            rs = ($urandom_range(0, 99) < 3) || (!m_busy && ($urandom_range(0, 99) < 25));
            rv = ($urandom_range(0, 99) < 60);
            rc = ($urandom_range(0, 99) < 10);
            applyStimulus(rs, rv, rc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
